// File: rtl/deser_pkg.sv
// Types and constants shared by the deserializer and the byte queue that follows it.
package deser_pkg;

  localparam int BYTE_W = 8;

  // Accept-side handshake states of byte_queue_ctrl.
  typedef enum logic [1:0] {Q_IDLE, Q_ACK, Q_WAIT_LOW} qstate_t;

  // Deserializer receive states.
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_READY} state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular DEPTH-entry byte FIFO with show-ahead head output and occupancy count.
module byte_fifo
  import deser_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = BYTE_W
) (
  input  logic                     clock_100k,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   len_out,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    len;

  logic do_wr;
  logic do_rd;

  // Gating uses the occupancy held before the edge, so a pop never frees a slot for a same-edge write.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      len    <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   len <= len + LW'(1);
        2'b01:   len <= len - LW'(1);
        default: len <= len;
      endcase
    end
  end

  assign full     = (len == LW'(DEPTH));
  assign empty    = (len == '0);
  assign len_out  = len;
  assign data_out = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/byte_queue_ctrl.sv
// Accepts bytes from the deserializer handshake into byte_fifo, stalling the ack while full.
module byte_queue_ctrl
  import deser_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = BYTE_W
) (
  input  logic                     clock_100k,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         des_data,
  input  logic                     des_ready,
  output logic                     ack_out,
  input  logic                     deq_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   len_out,
  output logic                     full,
  output logic                     empty
);

  qstate_t state_reg;
  qstate_t state_next;
  logic    ack_reg;
  logic    ack_next;
  logic    wr_en;
  logic    rd_en;

  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      state_reg <= Q_IDLE;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ack_next   = 1'b0;
    wr_en      = 1'b0;
    case (state_reg)
      Q_IDLE: begin
        // Holding off here while full keeps the deserializer parked in its ready state.
        if (des_ready && !full) begin
          wr_en      = 1'b1;
          ack_next   = 1'b1;
          state_next = Q_ACK;
        end
      end
      Q_ACK: begin
        state_next = Q_WAIT_LOW;
      end
      Q_WAIT_LOW: begin
        if (!des_ready) begin
          state_next = Q_IDLE;
        end
      end
      default: begin
        state_next = Q_IDLE;
      end
    endcase
  end

  assign rd_en   = deq_in && !empty;
  assign ack_out = ack_reg;

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clock_100k (clock_100k),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (des_data),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .len_out    (len_out),
    .full       (full),
    .empty      (empty)
  );

endmodule

// File: tb/tb_byte_queue_ctrl.sv
// Scoreboard bench for byte_queue_ctrl: stimulus queues expected bytes, a monitor checks each pop.
module tb_byte_queue_ctrl;

  logic       clock_100k = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] des_data   = 8'h00;
  logic       des_ready  = 1'b0;
  logic       ack_out;
  logic       deq_in     = 1'b0;
  logic [7:0] data_out;
  logic [3:0] len_out;
  logic       full;
  logic       empty;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  always #5 clock_100k = ~clock_100k;

  byte_queue_ctrl #(.DEPTH(8), .WIDTH(8)) dut (
    .clock_100k (clock_100k),
    .reset      (reset),
    .des_data   (des_data),
    .des_ready  (des_ready),
    .ack_out    (ack_out),
    .deq_in     (deq_in),
    .data_out   (data_out),
    .len_out    (len_out),
    .full       (full),
    .empty      (empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock_100k);
    #1;
  endtask

  // Deserializer model: data_ready high until after the ack cycle, plus optional extra hold.
  task automatic send(input logic [7:0] b, input int hold);
    des_data  = b;
    des_ready = 1'b1;
    exp_q.push_back(b);
    tick();
    chk("ack_rise", {31'd0, ack_out}, 32'd1);
    repeat (hold) begin
      tick();
      chk("ack_hold", {31'd0, ack_out}, 32'd0);
    end
    tick();
    chk("ack_fall", {31'd0, ack_out}, 32'd0);
    des_ready = 1'b0;
    tick();
  endtask

  task automatic pop();
    deq_in = 1'b1;
    tick();
    deq_in = 1'b0;
  endtask

  // Monitor: whenever a pop is presented to a non-empty FIFO, the head must match the scoreboard.
  always @(negedge clock_100k) begin
    if (!reset && deq_in && !empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_data: got %0h expected nothing queued", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("pop_data", {24'd0, data_out}, {24'd0, mon_exp});
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock_100k);
    #1;
    reset = 1'b0;

    // Reset then idle: {ack, empty, full, len, data}
    repeat (20) begin
      chk("idle", {17'd0, ack_out, empty, full, len_out, data_out}, {17'd0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0});
      tick();
    end

    // Single byte, des_ready held high longer to prove no second write.
    send(8'hA5, 3);
    chk("a5_len", {28'd0, len_out}, 32'd1);
    chk("a5_data", {24'd0, data_out}, 32'hA5);
    pop();
    chk("a5_empty", {31'd0, empty}, 32'd1);

    // Fill to DEPTH.
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 0);
    end
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_len", {28'd0, len_out}, 32'd8);
    chk("fill_head", {24'd0, data_out}, 32'h01);

    // Ninth byte stalls until a pop; accepted one edge after the pop.
    des_data  = 8'h09;
    des_ready = 1'b1;
    exp_q.push_back(8'h09);
    repeat (4) begin
      tick();
      chk("stall_ack", {31'd0, ack_out}, 32'd0);
    end
    chk("stall_len", {28'd0, len_out}, 32'd8);
    deq_in = 1'b1;
    tick();
    deq_in = 1'b0;
    chk("stall_pop_ack", {31'd0, ack_out}, 32'd0);
    chk("stall_pop_len", {28'd0, len_out}, 32'd7);
    tick();
    chk("stall_accept_ack", {31'd0, ack_out}, 32'd1);
    chk("stall_accept_len", {28'd0, len_out}, 32'd8);
    des_ready = 1'b0;
    tick();
    chk("stall_ack_fall", {31'd0, ack_out}, 32'd0);
    tick();

    // Drain with wrap: rd_ptr went 1 -> 2 (mod 8) across nine pops.
    repeat (8) pop();
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_len", {28'd0, len_out}, 32'd0);
    chk("drain_data", {24'd0, data_out}, 32'd0);
    chk("drain_rd_ptr", {29'd0, dut.u_fifo.rd_ptr}, 32'd2);
    chk("drain_sb", exp_q.size(), 32'd0);

    // Simultaneous write and pop at len 3.
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    chk("sim_len_pre", {28'd0, len_out}, 32'd3);
    des_data  = 8'h44;
    des_ready = 1'b1;
    deq_in    = 1'b1;
    exp_q.push_back(8'h44);
    tick();
    deq_in = 1'b0;
    chk("sim_ack", {31'd0, ack_out}, 32'd1);
    chk("sim_len", {28'd0, len_out}, 32'd3);
    chk("sim_head", {24'd0, data_out}, 32'h22);
    des_ready = 1'b0;
    tick();
    tick();
    repeat (3) pop();
    chk("sim_empty", {31'd0, empty}, 32'd1);

    // Pop on empty changes nothing.
    pop();
    chk("empty_pop_len", {28'd0, len_out}, 32'd0);
    chk("empty_pop_empty", {31'd0, empty}, 32'd1);
    chk("empty_pop_data", {24'd0, data_out}, 32'd0);
    chk("empty_pop_rd_ptr", {29'd0, dut.u_fifo.rd_ptr}, 32'd6);
    chk("empty_pop_wr_ptr", {29'd0, dut.u_fifo.wr_ptr}, 32'd6);

    // Reset while ack_out is high with four bytes stored.
    send(8'h51, 0);
    send(8'h52, 0);
    send(8'h53, 0);
    des_data  = 8'h54;
    des_ready = 1'b1;
    tick();
    chk("rst_pre_ack", {31'd0, ack_out}, 32'd1);
    chk("rst_pre_len", {28'd0, len_out}, 32'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async", {17'd0, ack_out, empty, full, len_out, data_out}, {17'd0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0});
    exp_q.delete();
    des_ready = 1'b0;
    @(posedge clock_100k);
    #1;
    reset = 1'b0;
    chk("rst_release", {17'd0, ack_out, empty, full, len_out, data_out}, {17'd0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0});
    chk("rst_ptrs", {26'd0, dut.u_fifo.rd_ptr, dut.u_fifo.wr_ptr}, 32'd0);

    send(8'h3C, 0);
    chk("post_rst_len", {28'd0, len_out}, 32'd1);
    chk("post_rst_data", {24'd0, data_out}, 32'h3C);
    pop();
    chk("post_rst_empty", {31'd0, empty}, 32'd1);
    chk("final_sb", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
